// File: rtl/alumux.sv
// Operand-select encodings for the two ALU input muxes.
package alumux;
    typedef enum logic {
        rs1_out = 1'b0,
        pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        i_imm   = 3'd0,
        u_imm   = 3'd1,
        b_imm   = 3'd2,
        s_imm   = 3'd3,
        j_imm   = 3'd4,
        rs2_out = 3'd5
    } alumux2_sel_t;
endpackage

// File: rtl/cmpmux.sv
// Second-operand select for the branch comparator.
package cmpmux;
    typedef enum logic {
        rs2_out = 1'b0,
        i_imm   = 1'b1
    } cmpmux_sel_t;
endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I control encodings: branch compare ops and ALU ops.
package rv32i_types;
    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;
endpackage

// File: rtl/id_ex_buffer.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush
// insertion and bubble/flush performance counters.
module id_ex_buffer
    import rv32i_types::*;
#(
    parameter logic [31:0] NOP_IR = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic                   flush_i,
    input  logic                   id_valid_i,
    input  logic [31:0]            id_pc_i,
    input  logic [31:0]            id_ir_i,
    input  logic [31:0]            id_rs1_data_i,
    input  logic [31:0]            id_rs2_data_i,
    input  alumux::alumux1_sel_t   id_alumux1_sel_i,
    input  alumux::alumux2_sel_t   id_alumux2_sel_i,
    input  branch_funct3_t         id_cmpop_i,
    input  alu_ops                 id_aluop_i,
    input  cmpmux::cmpmux_sel_t    id_cmpmux_sel_i,
    input  logic                   id_load_regfile_i,
    input  logic                   id_mem_read_i,
    input  logic                   id_mem_write_i,
    output logic                   ex_valid_o,
    output logic [31:0]            ex_pc_o,
    output logic [31:0]            ex_ir_o,
    output logic [31:0]            ex_rs1_data_o,
    output logic [31:0]            ex_rs2_data_o,
    output alumux::alumux1_sel_t   ex_alumux1_sel_o,
    output alumux::alumux2_sel_t   ex_alumux2_sel_o,
    output branch_funct3_t         ex_cmpop_o,
    output alu_ops                 ex_aluop_o,
    output cmpmux::cmpmux_sel_t    ex_cmpmux_sel_o,
    output logic                   ex_load_regfile_o,
    output logic                   ex_mem_read_o,
    output logic                   ex_mem_write_o,
    output logic                   hazard_stall_o,
    output logic [31:0]            bubble_cnt_o,
    output logic [31:0]            flush_cnt_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          pc;
        logic [31:0]          ir;
        logic [31:0]          rs1_data;
        logic [31:0]          rs2_data;
        alumux::alumux1_sel_t alumux1_sel;
        alumux::alumux2_sel_t alumux2_sel;
        branch_funct3_t       cmpop;
        alu_ops               aluop;
        cmpmux::cmpmux_sel_t  cmpmux_sel;
        logic                 load_regfile;
        logic                 mem_read;
        logic                 mem_write;
    } ex_rec_t;

    // A bubble is an architecturally inert NOP with no register or memory side effects.
    localparam ex_rec_t C_BUBBLE = '{
        valid:        1'b0,
        pc:           32'h0,
        ir:           NOP_IR,
        rs1_data:     32'h0,
        rs2_data:     32'h0,
        alumux1_sel:  alumux::rs1_out,
        alumux2_sel:  alumux::i_imm,
        cmpop:        beq,
        aluop:        alu_add,
        cmpmux_sel:   cmpmux::rs2_out,
        load_regfile: 1'b0,
        mem_read:     1'b0,
        mem_write:    1'b0
    };

    ex_rec_t     r_ex;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    ex_rec_t     w_id_rec;
    logic [6:0]  w_id_opcode;
    logic [4:0]  w_rd_ex;
    logic        w_uses_rs1;
    logic        w_uses_rs2;
    logic        w_hazard;

    assign w_id_rec = '{
        valid:        id_valid_i,
        pc:           id_pc_i,
        ir:           id_ir_i,
        rs1_data:     id_rs1_data_i,
        rs2_data:     id_rs2_data_i,
        alumux1_sel:  id_alumux1_sel_i,
        alumux2_sel:  id_alumux2_sel_i,
        cmpop:        id_cmpop_i,
        aluop:        id_aluop_i,
        cmpmux_sel:   id_cmpmux_sel_i,
        load_regfile: id_load_regfile_i,
        mem_read:     id_mem_read_i,
        mem_write:    id_mem_write_i
    };

    assign w_id_opcode = id_ir_i[6:0];
    assign w_rd_ex     = r_ex.ir[11:7];

    always_comb begin
        w_uses_rs1 = !((w_id_opcode == OPC_LUI) || (w_id_opcode == OPC_AUIPC) ||
                       (w_id_opcode == OPC_JAL));
        w_uses_rs2 = (w_id_opcode == OPC_OP) || (w_id_opcode == OPC_BRANCH) ||
                     (w_id_opcode == OPC_STORE);
    end

    // Load in EX whose destination is read by the ID instruction: data not ready yet.
    assign w_hazard = r_ex.valid && r_ex.mem_read && r_ex.load_regfile &&
                      (w_rd_ex != 5'd0) && id_valid_i &&
                      ((w_uses_rs1 && (w_rd_ex == id_ir_i[19:15])) ||
                       (w_uses_rs2 && (w_rd_ex == id_ir_i[24:20])));

    // A redirect discards the ID instruction, so there is nothing to stall for.
    assign hazard_stall_o = w_hazard && !flush_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex         <= C_BUBBLE;
            r_bubble_cnt <= 32'h0;
            r_flush_cnt  <= 32'h0;
        end else if (flush_i) begin
            r_ex         <= C_BUBBLE;
            r_flush_cnt  <= r_flush_cnt + 32'd1;
        end else if (!load_i) begin
            r_ex         <= r_ex;
        end else if (w_hazard) begin
            r_ex         <= C_BUBBLE;
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end else begin
            r_ex         <= w_id_rec;
        end
    end

    assign ex_valid_o        = r_ex.valid;
    assign ex_pc_o           = r_ex.pc;
    assign ex_ir_o           = r_ex.ir;
    assign ex_rs1_data_o     = r_ex.rs1_data;
    assign ex_rs2_data_o     = r_ex.rs2_data;
    assign ex_alumux1_sel_o  = r_ex.alumux1_sel;
    assign ex_alumux2_sel_o  = r_ex.alumux2_sel;
    assign ex_cmpop_o        = r_ex.cmpop;
    assign ex_aluop_o        = r_ex.aluop;
    assign ex_cmpmux_sel_o   = r_ex.cmpmux_sel;
    assign ex_load_regfile_o = r_ex.load_regfile;
    assign ex_mem_read_o     = r_ex.mem_read;
    assign ex_mem_write_o    = r_ex.mem_write;
    assign bubble_cnt_o      = r_bubble_cnt;
    assign flush_cnt_o       = r_flush_cnt;

endmodule

// File: doc/id_ex_buffer.md
ID_EX_BUFFER -- requirements
Module: id_ex_buffer

Interface
REQ-001 SHALL have parameter NOP_IR, default 32'h0000_0013, meaning the instruction word loaded on a bubble, flush or reset.
REQ-002 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: load_i  in  1  pipeline advance; 0 = global stall, hold contents.
REQ-005 SHALL have ports: flush_i  in  1  squash the ID-stage instruction (branch/jump redirect).
REQ-006 SHALL have ports: id_valid_i  in  1; id_pc_i  in  32; id_ir_i  in  32; id_rs1_data_i  in  32; id_rs2_data_i  in  32  (ID-stage instruction and register-file reads).
REQ-007 SHALL have ports: id_alumux1_sel_i  in  alumux::alumux1_sel_t; id_alumux2_sel_i  in  alumux::alumux2_sel_t; id_cmpop_i  in  branch_funct3_t; id_aluop_i  in  alu_ops; id_cmpmux_sel_i  in  cmpmux::cmpmux_sel_t; id_load_regfile_i, id_mem_read_i, id_mem_write_i  in  1 each  (ID control word).
REQ-008 SHALL have outputs ex_valid_o 1, ex_pc_o 32, ex_ir_o 32, ex_rs1_data_o 32, ex_rs2_data_o 32, plus ex_* copies of every REQ-007 control field, all driven directly from registers.
REQ-009 SHALL have output hazard_stall_o  1  combinational; IF/ID must hold when 1.
REQ-010 SHALL have outputs bubble_cnt_o  32  and flush_cnt_o  32  (performance counters).

Function
REQ-011 SHALL define the bubble state: valid=0, ir=NOP_IR, pc=0, rs1/rs2 data=0, load_regfile=mem_read=mem_write=0, aluop=add, alumux1=rs1_out, alumux2=i_imm, cmpop=beq, cmpmux=rs2_out.
REQ-012 SHALL compute hazard (load-use) as: ex_valid_o & ex_mem_read_o & ex_load_regfile_o & rd_ex!=0 & id_valid_i & ((uses_rs1 & rd_ex==id_ir_i[19:15]) | (uses_rs2 & rd_ex==id_ir_i[24:20])), rd_ex=ex_ir_o[11:7].
REQ-013 SHALL set uses_rs1=1 except for opcodes LUI 0110111, AUIPC 0010111, JAL 1101111; uses_rs2=1 only for OP 0110011, BRANCH 1100011, STORE 0100011.
REQ-014 SHALL drive hazard_stall_o = hazard & ~flush_i, independent of load_i.
REQ-015 SHALL update on each rising edge with priority: flush_i -> bubble; else load_i=0 -> hold all; else hazard -> bubble; else capture all id_* inputs.
REQ-016 SHALL have latency one cycle: values captured at edge N appear on ex_* from edge N onward until the next update.
REQ-017 SHALL squash on flush_i even when load_i=0 (flush wins over stall).
REQ-018 SHALL insert exactly one bubble per load-use pair; after the bubble, EX holds a non-load so hazard deasserts without extra state.
REQ-019 SHALL increment bubble_cnt_o by 1 on each edge taking the hazard branch of REQ-015; flush or hold edges SHALL NOT count.
REQ-020 SHALL increment flush_cnt_o by 1 on each edge with flush_i=1, regardless of load_i.
REQ-021 SHALL wrap both counters modulo 2^32 (0xFFFF_FFFF -> 0) with no saturation or flag.
REQ-022 SHALL capture id_valid_i=0 as-is (no forced bubble); hazard requires id_valid_i=1.

Reset
REQ-023 SHALL, while rst=1, immediately force all EX registers to the bubble state and both counters to 0, without waiting for clk.
REQ-024 SHALL abandon any in-progress hazard on reset; first edge after rst deasserts behaves per REQ-015 with EX empty (hazard_stall_o=0).

Verification
REQ-025 Reset mid-run: rst pulsed between edges with ex_valid_o=1 -> ex_ir_o=0x0000_0013, ex_valid_o=0, counters=0 before next edge.
REQ-026 Load-use: EX=lw x5 (ir 0x0000_2283), ID=add x6,x5,x1 -> hazard_stall_o=1; next edge EX=bubble, bubble_cnt_o=1; following edge EX=add, hazard_stall_o=0.
REQ-027 No false hazard: EX=lw x0 or EX=lw x5 with ID=lui x5,1 -> hazard_stall_o=0, ID captured next edge.
REQ-028 Stall then flush: load_i=0 for 3 edges -> ex_* unchanged; then load_i=0, flush_i=1 -> bubble, flush_cnt_o+1, bubble_cnt_o unchanged.
REQ-029 Simultaneous hazard and flush -> hazard_stall_o=0, bubble loaded, flush_cnt_o+1, bubble_cnt_o unchanged.
REQ-030 Counter wrap: force flush_cnt_o to 0xFFFF_FFFF (via 2^32-1 flushes or backdoor), one flush -> 0x0000_0000.
